// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD down-counting timer.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Out-of-range BCD codes (A..F) are treated as the largest legal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down counter. Loads a clamped value, or steps down
// by one when a borrow arrives, wrapping 0 -> 9 and passing the borrow on.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       bin,
  output logic [3:0] q,
  output logic       bout,
  output logic       zero
);

  bcd_digit_t q_reg;

  // Digit register: reset/clear to 0, load clamped preset, or decrement on borrow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= bcd_clamp(ld_val);
    end else if (bin) begin
      q_reg <= (q_reg == 4'd0) ? BCD_MAX : q_reg - 4'd1;
    end
  end

  assign q    = q_reg;
  assign zero = (q_reg == 4'd0);
  // A decade at zero that is asked to decrement wraps and borrows from the next one.
  assign bout = bin & zero;

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counting timer with start/pause/clear control and a
// one-cycle done pulse when the count reaches zero.
// Optional feature macro: AUTO_RELOAD_EN -- when defined, reaching zero in
// RUN reloads the preset and keeps running (periodic timer).
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] cnt,
  output logic                busy,
  output logic                done
);

  state_t state_reg;
  state_t state_next;
  logic   busy_reg;
  logic   done_reg;
  logic   done_next;

  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] dig_zero;
  logic              dig_load;
  logic              start_go;
  logic              run_tick;
  logic              reload;
  logic              cnt_zero;
  logic              cnt_is_one;
  logic              preset_zero;
  logic              unused_borrow;

  assign cnt_zero    = &dig_zero;
  assign cnt_is_one  = (cnt == {{(4*DIGITS-1){1'b0}}, 1'b1});
  assign preset_zero = (preset == '0);

  // Decode which datapath action this cycle performs, honouring clear > start > pause > tick.
  always_comb begin
    start_go = !clear && start && ((state_reg == IDLE) || (state_reg == DONE));
    run_tick = !clear && (state_reg == RUN) && !pause && tick;
    reload   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload   = run_tick && cnt_is_one;
`endif
    dig_load  = start_go || reload;
    // The count never goes below zero, so the decrement is gated on a non-zero value.
    borrow[0] = run_tick && !reload && !cnt_zero;
  end

  // The top decade can never borrow because the chain is only fed when cnt > 0.
  assign unused_borrow = borrow[DIGITS];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_down_digit u_digit (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (clear),
        .load   (dig_load),
        .ld_val (preset[4*gi +: 4]),
        .bin    (borrow[gi]),
        .q      (cnt[4*gi +: 4]),
        .bout   (borrow[gi+1]),
        .zero   (dig_zero[gi])
      );
    end
  endgenerate

  // Next-state and done-pulse decode for the control FSM.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            if (preset_zero) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSE;
          end else if (tick && cnt_is_one) begin
            done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
            state_next = preset_zero ? DONE : RUN;
`else
            state_next = DONE;
`endif
          end
        end
        PAUSE: begin
          if (!pause) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control FSM with registered busy (from next state) and done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN) || (state_next == PAUSE);
      done_reg  <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer (DIGITS=2). The driver applies one
// input vector per cycle and queues the outputs expected after that edge;
// a monitor on the falling edge pops and compares them.
module tb_bcd_down_timer;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       clear  = 1'b0;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic       tick   = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [7:0] cnt;
  logic       busy;
  logic       done;

  bcd_down_timer #(.DIGITS(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (clear),
    .start  (start),
    .pause  (pause),
    .tick   (tick),
    .preset (preset),
    .cnt    (cnt),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  cnt;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    errors = 0;
  int    checks = 0;
  exp_t  mon_e;
  string mon_nm;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // One cycle of stimulus plus the outputs expected right after the next rising edge.
  task automatic drive(input logic r, input logic c, input logic s, input logic p,
                       input logic t, input logic [7:0] pre, input string nm,
                       input logic [7:0] ecnt, input logic eb, input logic ed);
    @(negedge clk);
    rstn   = r;
    clear  = c;
    start  = s;
    pause  = p;
    tick   = t;
    preset = pre;
    sb.push_back('{due: 32'(cyc + 1), cnt: ecnt, busy: eb, done: ed});
    sb_name.push_back(nm);
  endtask

  // Monitor: compare every queued expectation that has come due.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= 32'(cyc)) begin
      mon_e  = sb.pop_front();
      mon_nm = sb_name.pop_front();
      checks++;
      if (mon_e.due != 32'(cyc) || cnt !== mon_e.cnt || busy !== mon_e.busy || done !== mon_e.done) begin
        errors++;
        $display("FAIL %s: got cnt=%h busy=%b done=%b, want cnt=%h busy=%b done=%b",
                 mon_nm, cnt, busy, done, mon_e.cnt, mon_e.busy, mon_e.done);
      end else begin
        $display("ok   %s: cnt=%h busy=%b done=%b", mon_nm, cnt, busy, done);
      end
    end
  end

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 8'h00, "reset",       8'h00, 0, 0);
    drive(0, 0, 1, 0, 1, 8'h45, "reset_hold",  8'h00, 0, 0);

    // 1: reset in the middle of a count
    drive(1, 0, 1, 0, 0, 8'h37, "t1_load",      8'h37, 1, 0);
    drive(1, 0, 0, 0, 0, 8'h37, "t1_no_tick",   8'h37, 1, 0);
    drive(0, 0, 0, 0, 1, 8'h37, "t1_rstn",      8'h00, 0, 0);
    drive(1, 0, 0, 0, 1, 8'h37, "t1_idle_tick", 8'h00, 0, 0);

`ifndef AUTO_RELOAD_EN
    // 2: one-shot count 12 -> 00, done only on the 12th tick
    drive(1, 0, 1, 0, 0, 8'h12, "t2_load", 8'h12, 1, 0);
    for (int k = 1; k <= 12; k++)
      drive(1, 0, 0, 0, 1, 8'h12, $sformatf("t2_tick%0d", k), to_bcd(12 - k), k < 12, k == 12);
    drive(1, 0, 0, 0, 1, 8'h12, "t2_done_hold", 8'h00, 0, 0);
`endif

    // 3: borrow across decades, start ignored in RUN, clamp on load
    drive(1, 0, 1, 0, 0, 8'h10, "t3_load10",       8'h10, 1, 0);
    drive(1, 0, 0, 0, 1, 8'h10, "t3_borrow",       8'h09, 1, 0);
    drive(1, 0, 1, 0, 1, 8'hAF, "t3_start_in_run", 8'h08, 1, 0);
    drive(1, 1, 0, 0, 0, 8'hAF, "t3_clear",        8'h00, 0, 0);
    drive(1, 0, 1, 0, 0, 8'hAF, "t3_clamp",        8'h99, 1, 0);
    drive(1, 0, 0, 0, 1, 8'hAF, "t3_tick",         8'h98, 1, 0);

    // 4: pause holds the count while ticks keep arriving
    for (int i = 0; i < 5; i++)
      drive(1, 0, 0, 1, 1, 8'hAF, $sformatf("t4_pause%0d", i), 8'h98, 1, 0);
    drive(1, 0, 0, 0, 0, 8'hAF, "t4_release", 8'h98, 1, 0);
    drive(1, 0, 0, 0, 1, 8'hAF, "t4_resume",  8'h97, 1, 0);

    // tick in the same cycle as start only loads
    drive(1, 1, 0, 0, 0, 8'h25, "t4_clear",      8'h00, 0, 0);
    drive(1, 0, 1, 0, 1, 8'h25, "t4_start_tick", 8'h25, 1, 0);
    drive(1, 0, 0, 0, 1, 8'h25, "t4_tick",       8'h24, 1, 0);

    // 5: clear beats start; zero preset goes straight to DONE
    drive(1, 1, 1, 0, 0, 8'h55, "t5_clear_start", 8'h00, 0, 0);
    drive(1, 0, 1, 0, 0, 8'h00, "t5_zero_start",  8'h00, 0, 1);
    drive(1, 0, 0, 0, 1, 8'h00, "t5_after",       8'h00, 0, 0);
    drive(1, 0, 1, 0, 0, 8'h00, "t5_zero_again",  8'h00, 0, 1);
    drive(1, 0, 1, 0, 0, 8'h02, "t5_restart",     8'h02, 1, 0);
    drive(1, 0, 0, 0, 1, 8'h02, "t5_tick",        8'h01, 1, 0);
    drive(1, 1, 0, 0, 1, 8'h02, "t5_clear_run",   8'h00, 0, 0);

`ifdef AUTO_RELOAD_EN
    // 6: periodic reload every 3 ticks
    drive(1, 0, 1, 0, 0, 8'h03, "t6_load", 8'h03, 1, 0);
    for (int k = 1; k <= 9; k++)
      drive(1, 0, 0, 0, 1, 8'h03, $sformatf("t6_tick%0d", k),
            (k % 3 == 0) ? 8'h03 : to_bcd(3 - (k % 3)), 1, (k % 3) == 0);
`endif

    drive(1, 0, 0, 0, 0, 8'h00, "idle_end", 8'h00, 0, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL pending: %0d expectations never compared", sb.size());
      errors += sb.size();
      checks += sb.size();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
